// File: rtl/pc_return_stack.sv
// Return-address stack for the PIC16F84-class core.
// Circular buffer addressed by a top pointer, with an occupancy count,
// full/empty flags, sticky overflow/underflow and single-cycle replace-top.
module pc_return_stack #(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             clr_err,
    output logic [WIDTH-1:0] top_pc,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] TP_MAX  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    // Storage is a plain register array: every entry must clear on reset,
    // which rules out mapping it onto block RAM.
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    tp_reg, tp_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] top_reg, top_next;
    logic             overflow_reg, underflow_reg;
    logic             ovf_set, unf_set;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [PW-1:0]    tp_inc, tp_dec;
    logic [DEPTH-1:0] wr_sel;

    // Pointer neighbours wrap modulo DEPTH, which need not be a power of two.
    assign tp_inc = (tp_reg == TP_MAX) ? '0 : tp_reg + PW'(1);
    assign tp_dec = (tp_reg == '0) ? TP_MAX : tp_reg - PW'(1);

    assign empty = (count_reg == '0);
    assign full  = (count_reg == COUNT_MAX);

    // Decode the requested operation into next pointer/count/top and a write.
    always_comb begin
        tp_next    = tp_reg;
        count_next = count_reg;
        top_next   = top_reg;
        wr_en      = 1'b0;
        wr_addr    = tp_inc;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (en) begin
            if (push && pop && !empty) begin
                // Replace-top: overwrite in place, nothing else moves.
                wr_en    = 1'b1;
                wr_addr  = tp_reg;
                top_next = in_pc;
            end else if (push) begin
                // Also covers push+pop on an empty stack.
                if (!full) begin
                    tp_next    = tp_inc;
                    wr_en      = 1'b1;
                    count_next = count_reg + CW'(1);
                    top_next   = in_pc;
                end else if (WRAP_MODE != 0) begin
                    // Next slot holds the oldest entry; it is sacrificed.
                    tp_next  = tp_inc;
                    wr_en    = 1'b1;
                    top_next = in_pc;
                    ovf_set  = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (pop) begin
                if (!empty) begin
                    tp_next    = tp_dec;
                    count_next = count_reg - CW'(1);
                    top_next   = (count_reg == CW'(1)) ? '0 : mem_reg[tp_dec];
                end else begin
                    unf_set  = 1'b1;
                    top_next = '0;
                end
            end
        end
    end

    // One-hot write select per entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wr_sel[gi] = wr_en && (wr_addr == PW'(gi));
        end
    endgenerate

    // Entry storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) mem_reg[i] <= in_pc;
            end
        end
    end

    // Pointer, count, registered top and sticky flags (set beats clear).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tp_reg        <= '0;
            count_reg     <= '0;
            top_reg       <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            tp_reg        <= tp_next;
            count_reg     <= count_next;
            top_reg       <= top_next;
            overflow_reg  <= ovf_set | (overflow_reg & ~clr_err);
            underflow_reg <= unf_set | (underflow_reg & ~clr_err);
        end
    end

    assign top_pc    = top_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench for pc_return_stack: one wrapping and one discarding
// instance share stimulus; a queue-based model predicts each cycle's outputs.
module tb_pc_return_stack;

    localparam int W = 10;
    localparam int D = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [W-1:0] in_pc = '0;

    logic [W-1:0] top_w, top_d;
    logic [3:0]   cnt_w, cnt_d;
    logic         emp_w, emp_d, ful_w, ful_d, ovf_w, ovf_d, unf_w, unf_d;

    pc_return_stack #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(1)) u_wrap (
        .clock(clock), .reset(reset), .en(en), .push(push), .pop(pop),
        .in_pc(in_pc), .clr_err(clr_err), .top_pc(top_w), .count(cnt_w),
        .empty(emp_w), .full(ful_w), .overflow(ovf_w), .underflow(unf_w)
    );

    pc_return_stack #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(0)) u_drop (
        .clock(clock), .reset(reset), .en(en), .push(push), .pop(pop),
        .in_pc(in_pc), .clr_err(clr_err), .top_pc(top_d), .count(cnt_d),
        .empty(emp_d), .full(ful_d), .overflow(ovf_d), .underflow(unf_d)
    );

    always #5 clock = ~clock;

    // Expected outputs: {top[9:0], count[3:0], empty, full, overflow, underflow}
    typedef struct {
        logic [17:0] w;
        logic [17:0] d;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a list of live return addresses, oldest first.
    int unsigned stk_w[$];
    int unsigned stk_d[$];
    int unsigned last_top_w, last_top_d;
    bit          mo_w, mu_w, mo_d, mu_d;

    function automatic logic [17:0] pack(int unsigned top, int n, bit o, bit u);
        return {top[9:0], n[3:0], (n == 0), (n == D), o, u};
    endfunction

    task automatic model_reset();
        stk_w.delete(); stk_d.delete();
        last_top_w = 0; last_top_d = 0;
        mo_w = 0; mu_w = 0; mo_d = 0; mu_d = 0;
    endtask

    // Applies one cycle's operation to one model stack.
    task automatic model_step(input bit wrap, input bit e, input bit pu, input bit po,
                              input int unsigned pc, input bit clr,
                              inout int unsigned stk[$], inout int unsigned top,
                              inout bit o, inout bit u);
        bit so = 0, su = 0;
        if (e) begin
            if (pu && po && stk.size() > 0) begin
                stk[stk.size()-1] = pc;
                top = pc;
            end else if (pu) begin
                if (stk.size() < D) begin
                    stk.push_back(pc);
                    top = pc;
                end else begin
                    so = 1;
                    if (wrap) begin
                        void'(stk.pop_front());
                        stk.push_back(pc);
                        top = pc;
                    end
                end
            end else if (po) begin
                if (stk.size() > 0) begin
                    void'(stk.pop_back());
                    top = (stk.size() > 0) ? stk[stk.size()-1] : 0;
                end else begin
                    su = 1;
                    top = 0;
                end
            end
        end
        o = so | (o & ~clr);
        u = su | (u & ~clr);
    endtask

    // Drive one cycle of stimulus and queue the predicted result.
    task automatic op(input bit e, input bit pu, input bit po,
                      input int unsigned pc, input bit clr, input string tag);
        exp_t x;
        @(negedge clock);
        en = e; push = pu; pop = po; in_pc = pc[W-1:0]; clr_err = clr;
        model_step(1'b1, e, pu, po, pc, clr, stk_w, last_top_w, mo_w, mu_w);
        model_step(1'b0, e, pu, po, pc, clr, stk_d, last_top_d, mo_d, mu_d);
        x.w = pack(last_top_w, stk_w.size(), mo_w, mu_w);
        x.d = pack(last_top_d, stk_d.size(), mo_d, mu_d);
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        exp_t x;
        @(negedge clock);
        en = 0; push = 0; pop = 0; clr_err = 0; in_pc = '0;
        #2;
        model_reset();
        x.w = pack(0, 0, 0, 0);
        x.d = pack(0, 0, 0, 0);
        x.tag = tag;
        exp_q.push_back(x);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: compare one queued expectation per clock edge or reset rise.
    always @(posedge clock or posedge reset) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [17:0] aw, ad;
            x  = exp_q.pop_front();
            aw = {top_w, cnt_w, emp_w, ful_w, ovf_w, unf_w};
            ad = {top_d, cnt_d, emp_d, ful_d, ovf_d, unf_d};
            tests++;
            if (aw !== x.w) begin
                fails++;
                $display("FAIL %s wrap: got top=%h cnt=%0d e=%b f=%b o=%b u=%b want top=%h cnt=%0d e=%b f=%b o=%b u=%b",
                         x.tag, aw[17:8], aw[7:4], aw[3], aw[2], aw[1], aw[0],
                         x.w[17:8], x.w[7:4], x.w[3], x.w[2], x.w[1], x.w[0]);
            end
            tests++;
            if (ad !== x.d) begin
                fails++;
                $display("FAIL %s drop: got top=%h cnt=%0d e=%b f=%b o=%b u=%b want top=%h cnt=%0d e=%b f=%b o=%b u=%b",
                         x.tag, ad[17:8], ad[7:4], ad[3], ad[2], ad[1], ad[0],
                         x.d[17:8], x.d[7:4], x.d[3], x.d[2], x.d[1], x.d[0]);
            end
            $display("[TB] %s top=%h/%h cnt=%0d/%0d", x.tag, top_w, top_d, cnt_w, cnt_d);
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clock);
        do_reset("reset");

        // Fill to 8 then one more push: wrap vs discard behaviour.
        for (int i = 1; i <= 9; i++) op(1, 1, 0, i, 0, $sformatf("push%0d", i));
        for (int i = 0; i < 9; i++) op(1, 0, 1, 0, 0, $sformatf("pop%0d", i));

        // Underflow stickiness and clear; set wins over clear.
        do_reset("reset2");
        op(1, 0, 1, 0, 0, "pop_empty");
        op(0, 0, 0, 0, 1, "clr_err");
        op(1, 0, 1, 0, 1, "pop_empty_clr");
        op(0, 0, 0, 0, 0, "idle");

        // Replace-top and push+pop on empty.
        do_reset("reset3");
        op(1, 1, 0, 'h100, 0, "push100");
        op(1, 1, 0, 'h200, 0, "push200");
        op(1, 1, 1, 'h3FF, 0, "replace");
        op(1, 0, 1, 0, 0, "pop_after_repl");
        op(1, 0, 1, 0, 0, "pop_last");
        op(1, 1, 1, 'h2A5, 0, "pushpop_empty");

        // Enable gating and asynchronous reset with live contents.
        do_reset("reset4");
        op(1, 1, 0, 'h055, 0, "push055");
        op(1, 1, 0, 'h0AA, 0, "push0AA");
        op(0, 1, 0, 'h123, 0, "push_en0");
        do_reset("async_reset");
        op(1, 1, 0, 'h011, 0, "push011");

        // Randomised traffic, biased so the stack both fills and drains.
        for (int i = 0; i < 400; i++) begin
            bit e, pu, po, c;
            e  = ($urandom_range(0, 7) != 0);
            pu = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 65 : 35));
            po = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 65));
            c  = ($urandom_range(0, 7) == 0);
            op(e, pu, po, $urandom_range(0, 1023), c, $sformatf("rnd%0d", i));
        end
        op(0, 0, 0, 0, 0, "final_idle");

        // Drain the scoreboard within a bounded number of cycles.
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Parametrised hardware return-address stack for the PIC16F84-class CPU core; replaces the fixed 8×10-bit shift stack.
- Circular buffer with a top pointer instead of shifting every entry.
- Adds occupancy count, full/empty flags, sticky overflow/underflow error flags, selectable full-stack policy, and single-cycle replace-top (simultaneous push+pop).
- Sits between the program counter logic (CALL/interrupt push, RETURN/RETLW/RETFIE pop) and the PC load mux.

Parameters:
- WIDTH, 10, bits per stored return address.
- DEPTH, 8, number of entries. Legal values: 2 to 64; need not be a power of two.
- WRAP_MODE, 1. 1 = push on full overwrites the oldest entry (PIC circular behaviour). 0 = push on full is discarded.
- CW, $clog2(DEPTH+1), width of count (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  operation enable; push/pop ignored when low
- push  in  1  push in_pc (qualified by en)
- pop  in  1  pop top entry (qualified by en)
- in_pc  in  WIDTH  return address to push
- clr_err  in  1  synchronous clear of overflow/underflow
- top_pc  out  WIDTH  registered top-of-stack value
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0 (combinational from count)
- full  out  1  count==DEPTH (combinational from count)
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, any time, including mid-operation): all mem entries=0, top pointer=0, count=0, top_pc=0, overflow=0, underflow=0. Takes effect immediately.
- Storage: mem[0..DEPTH-1]. Top pointer tp indexes the current top entry. Increment/decrement wrap modulo DEPTH: DEPTH-1+1 -> 0, 0-1 -> DEPTH-1.
- The operation is decoded when en=1. If en=0, the state holds and top_pc is unchanged.
- All state updates and top_pc update happen on the same rising edge. New top is visible after that edge (latency 1 edge, same as the current stack).
- push only, count<DEPTH: tp<=tp+1; mem[tp+1]<=in_pc; count+1; top_pc<=in_pc.
- push only, full, WRAP_MODE=1: same pointer/write as above (oldest overwritten); count stays DEPTH; overflow<=1; top_pc<=in_pc.
- push only, full, WRAP_MODE=0: no write, no pointer change; overflow<=1; top_pc unchanged.
- pop only, count>0: tp<=tp-1; count-1; top_pc<=mem[tp-1] if the new count>0, else 0. The popped slot is not cleared.
- pop only, empty: no state change; underflow<=1; top_pc<=0.
- push and pop together, count>0: replace top. mem[tp]<=in_pc; tp and count unchanged; top_pc<=in_pc; no flags.
- push and pop together, empty: treated as a plain push (count becomes 1); no underflow.
- clr_err=1: overflow<=0 and underflow<=0 on that edge, unless the same edge sets a flag; set wins over clear. clr_err is independent of en.
- Invariant: top_pc equals mem[tp] when count>0, and 0 when count==0.

Test Plan:
1. Reset, then push 0x001..0x008 (DEFAULT params) -> count=8, full=1, top_pc=0x008. Then 8 pops -> top_pc sequence 0x007..0x001, then 0; empty=1; underflow=0.
2. WRAP_MODE=1: push 0x001..0x009 -> overflow=1, count=8, top_pc=0x009. 8 pops return 0x008..0x002, then 0.
3. WRAP_MODE=0: push 0x001..0x009 -> overflow=1, count=8, top_pc=0x008. 8 pops return 0x007..0x001, then 0.
4. Pop while empty -> underflow=1, top_pc=0, count=0. Assert clr_err for one cycle -> underflow=0. Pop empty with clr_err=1 on the same cycle -> underflow stays 1.
5. Push 0x100, push 0x200, then push+pop with in_pc=0x3FF -> count=2, top_pc=0x3FF. Pop -> top_pc=0x100.
6. Push 0x055, 0x0AA with en=1; then push 0x123 with en=0 -> no change. Assert reset asynchronously mid-cycle -> all outputs 0 immediately. Push 0x011 -> count=1, top_pc=0x011.
